// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to transmitter and receiver,
// default bit period and frame length.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t IDLE      = 2'd0;
  localparam uart_state_t START_BIT = 2'd1;
  localparam uart_state_t DATA_BITS = 2'd2;
  localparam uart_state_t STOP_BIT  = 2'd3;

  localparam int unsigned DEFAULT_C  = 87;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_W     = 8;

  // Line level for a given frame position; data bits go out LSB first.
  function automatic logic frame_bit(input uart_state_t st, input logic [DATA_W-1:0] data,
                                     input logic [2:0] idx);
    case (st)
      START_BIT: return 1'b0;
      DATA_BITS: return data[idx];
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: tick is high on count C-1, counter then wraps to 0; clear holds it at 0.
// Latency: first tick C cycles after clear drops; no backpressure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned C = DEFAULT_C
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(C - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-byte holding register; line starts one cycle after accept.
// Backpressure: tx_ready low while the holding register is full; tx_start then is dropped.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned C = DEFAULT_C
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_serial
);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [2:0]  idx_q, idx_d;
  logic        serial_q, serial_d;
  logic        done_q, done_d;

  logic tick, timer_clr;
  logic accept, last_stop, chain_load, direct_load, hold_load;

  assign timer_clr = (state_q == IDLE);

  uart_bit_timer #(.C(C)) u_bit_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (timer_clr),
    .tick    (tick)
  );

  // A direct load on the final stop cycle is only possible with the holding register empty,
  // since accept itself requires it; so direct_load and chain_load never coincide.
  assign accept      = tx_start && !hold_full_q;
  assign last_stop   = (state_q == STOP_BIT) && tick;
  assign chain_load  = last_stop && hold_full_q;
  assign direct_load = accept && ((state_q == IDLE) || last_stop);
  assign hold_load   = accept && !direct_load;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (direct_load) state_d = START_BIT;
      START_BIT: if (tick) state_d = DATA_BITS;
      DATA_BITS: if (tick && (idx_q == 3'd7)) state_d = STOP_BIT;
      STOP_BIT:  if (tick) state_d = (chain_load || direct_load) ? START_BIT : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    idx_d       = idx_q;
    if (direct_load)     shift_d = tx_data;
    else if (chain_load) shift_d = hold_q;
    if (hold_load) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else if (chain_load) begin
      hold_full_d = 1'b0;
    end
    if ((state_q == START_BIT) && tick)      idx_d = 3'd0;
    else if ((state_q == DATA_BITS) && tick) idx_d = idx_q + 3'd1;
  end

  // Outputs are computed from next-state values so the registered line lines up with the state.
  always_comb begin
    serial_d = frame_bit(state_d, shift_d, idx_d);
    done_d   = last_stop;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      idx_q       <= '0;
      serial_q    <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      idx_q       <= idx_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_done   = done_q;
  assign tx_busy   = (state_q != IDLE);
  assign tx_ready  = !hold_full_q;

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART peripheral. It takes bytes from the APB-side register logic and serialises them onto `tx_serial` as 8N1 frames: one start bit, 8 data bits LSB first, one stop bit. Its line timing matches `uart_receiver` with the same `C`, so a direct `tx_serial` → `rx_serial` connection forms a loopback. A one-word holding register lets the host queue the next byte while the current frame is on the line.

## Interface
- `C`, default 87: PCLK cycles per bit. Legal range 2..255 (the receiver's counter is 8 bits).

- `PCLK`  in  1: clock; all state changes on rising edge.
- `PRESETn`  in  1: reset, asynchronous assert, active-low; one clock, reset async active-low.
- `tx_start`  in  1: byte-valid strobe; accepted on a PCLK edge when `tx_ready`=1.
- `tx_data`  in  8: byte sampled on the accepting edge.
- `tx_ready`  out  1: 1 = holding register empty, a byte can be accepted.
- `tx_busy`  out  1: 1 = a frame is on the line (state ≠ IDLE).
- `tx_done`  out  1: one-cycle pulse, asserted in the cycle after the final stop-bit cycle.
- `tx_serial`  out  1: serial line, registered, idles high.

## Operation
- The FSM states are IDLE, START_BIT, DATA_BITS and STOP_BIT, encoded 0..3 with the same encoding as the receiver.
- Registers:
  - shift register, 8 bits
  - holding register, 8 bits, plus `hold_full`
  - bit counter, 0..C-1
  - bit index, 3 bits
- Accept rule: `tx_start` && `tx_ready` at an edge.
  - If the state is IDLE, or the accept coincides with the final STOP_BIT cycle while the holding register is empty, the byte goes straight to the shift register and the state becomes START_BIT.
  - Otherwise the byte goes to the holding register and `hold_full` is set.
- A `tx_start` seen while `tx_ready`=0 is ignored; the byte is dropped and there is no error flag.
- START_BIT: `tx_serial`=0 for C cycles, then the state moves to DATA_BITS with bit index 0.
- DATA_BITS: `tx_serial`=shift[index] for C cycles per bit. After bit index 7 the state moves to STOP_BIT.
- STOP_BIT: `tx_serial`=1 for C cycles. At the final cycle:
  - `tx_done` is set for the next cycle.
  - If `hold_full` is set, the holding register moves to the shift register, `hold_full` is cleared and the state goes directly to START_BIT with no idle gap.
  - Otherwise the state goes to IDLE, unless a direct accept happens on the same edge.
- The counter resets to 0 on every bit boundary and counts 0..C-1. Its width is ceil(log2(C)); counter arithmetic wraps nowhere because the compare is at C-1.
- `tx_ready` = !`hold_full`, driven from a register.
- Reset values: `tx_serial`=1, `tx_busy`=0, `tx_done`=0, `tx_ready`=1, state IDLE, counters 0.
- Reset mid-frame: the line goes high immediately (asynchronous), and both the in-flight and held bytes are discarded.

## Timing
- Accept at edge k from IDLE: `tx_serial` falls and `tx_busy` rises after edge k.
- The start bit occupies cycles k+1..k+C, and data bit n occupies cycles k+1+(n+1)C .. k+(n+2)C.
- The stop bit ends at edge k+10C. `tx_done` is high during cycle k+10C+1 only; `tx_busy` falls at the same edge unless a chained frame starts.
- Back-to-back frames are exactly 10C cycles apart, with the line never returning to idle between them.
- Holding-register load at edge j: `tx_ready`=0 from j+1 until the edge where the held byte enters the shift register.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding localparams IDLE/START_BIT/DATA_BITS/STOP_BIT, used by both transmitter and receiver
  - the default C (87)
  - the frame length constant of 10 bits
- One natural sub-module, `uart_bit_timer`: parameter C, inputs PCLK, PRESETn and clear, output `tick`. `tick` is high on count C-1, and the counter auto-clears.

## Test plan
- Reset: hold PRESETn=0 for 3 cycles → `tx_serial`=1, `tx_ready`=1, `tx_busy`=0 and `tx_done`=0 throughout and after release.
- Single byte, C=4, `tx_data`=8'hA5 accepted at edge k → line is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1, then 1 for 4 cycles. `tx_done` pulses at cycle k+41.
- Loopback to `uart_receiver` #(C=4), sending 8'h00, 8'hFF and 8'h3C → `rx_parallel` matches each byte and `rx_done` pulses once per frame.
- Back-to-back: send 8'h12, then 8'h34 while busy → `tx_ready` drops. The second start bit begins the cycle right after the first stop bit, there is no idle cycle between frames, and there are two `tx_done` pulses 40 cycles apart.
- Overflow: with 8'h12 in flight and 8'h34 held, present 8'h56 → it is ignored, and only 8'h12 and 8'h34 appear on the line.
- Reset mid-frame: assert PRESETn low during DATA_BITS bit 3 → `tx_serial`=1 asynchronously. After release, a new byte 8'h81 transmits cleanly and the old byte never appears.
